axi4_wr_responder: RTL and testbench

AXI4_WR_RESPONDER -- requirements
Module: axi4_wr_responder

---
 rtl/axi4_wr_responder_if.sv | 46 ++++
 rtl/axi4_wr_responder.sv | 182 ++++++++++++++++++
 tb/tb_axi4_wr_responder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_wr_responder_if.sv
// ---------------------------------------------------------------------------
// axi4_wr_responder_if
// Write-channel bundle (AW, W, B) between an AXI4 write master and the
// axi4_wr_responder slave.
//   master modport : drives AW*, W*, BREADY; observes AWREADY, WREADY, B*
//   slave modport  : drives AWREADY, WREADY, BID, BRESP, BVALID
// ---------------------------------------------------------------------------
interface axi4_wr_responder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    // Write address channel
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;
    // Write data channel
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    // Write response channel
    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID,
        output BREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID,
        input  BREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID
    );
endinterface

// File: rtl/axi4_wr_responder.sv
// ---------------------------------------------------------------------------
// axi4_wr_responder
// AXI4 write slave in front of a simple word-addressed memory write port.
// Accepts one burst at a time (AW, then all W beats, then B), turns every
// beat of a legal burst into a one-cycle MEM_WEN pulse and reports
// OKAY / SLVERR / DECERR on the B channel.
// Ports:
//   CLK, RESET      sole clock, synchronous active-high reset
//   bus (slave)     AW / W / B channels
//   MEM_WEN         one-cycle write pulse per accepted beat of a legal burst
//   MEM_ADDR        memory word index
//   MEM_WDATA/WSTRB beat data and byte strobes
// ---------------------------------------------------------------------------
module axi4_wr_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 6
) (
    input  logic                    CLK,
    input  logic                    RESET,
    axi4_wr_responder_if.slave      bus,
    output logic                    MEM_WEN,
    output logic [MEM_DEPTH-1:0]    MEM_ADDR,
    output logic [DATA_WIDTH-1:0]   MEM_WDATA,
    output logic [DATA_WIDTH/8-1:0] MEM_WSTRB
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int B      = $clog2(STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t              state_q,  state_d;
    logic                awready_q, awready_d;
    logic                wready_q,  wready_d;
    logic                bvalid_q,  bvalid_d;
    logic [ID_WIDTH-1:0] id_q,      id_d;
    logic [MEM_DEPTH-1:0] idx_q,    idx_d;
    logic [7:0]          len_q,     len_d;
    logic [1:0]          burst_q,   burst_d;
    logic [1:0]          err_q,     err_d;    // address-phase code, gates writes
    logic [1:0]          resp_q,    resp_d;   // code reported on B
    logic [8:0]          beat_q,    beat_d;
    logic                mem_wen_q, mem_wen_d;
    logic [MEM_DEPTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic [1:0] aw_code;
    logic       last_beat;

    // Address-phase classification of the incoming burst.
    always_comb begin
        aw_code = RESP_OKAY;
        if ((bus.AWADDR >> (MEM_DEPTH + B)) != '0) begin
            aw_code = RESP_DECERR;
        end else if (bus.AWSIZE != 3'(B) || bus.AWBURST[1]) begin
            aw_code = RESP_SLVERR;
        end
    end

    assign last_beat = (beat_q == {1'b0, len_q});

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        idx_d       = idx_q;
        len_d       = len_q;
        burst_d     = burst_q;
        err_d       = err_q;
        resp_d      = resp_q;
        beat_d      = beat_q;
        mem_wen_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        case (state_q)
            IDLE: begin
                if (bus.AWVALID && awready_q) begin
                    id_d    = bus.AWID;
                    idx_d   = bus.AWADDR[MEM_DEPTH+B-1:B];
                    len_d   = bus.AWLEN;
                    burst_d = bus.AWBURST;
                    err_d   = aw_code;
                    resp_d  = aw_code;
                    beat_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus.WVALID && wready_q) begin
                    beat_d = beat_q + 9'd1;
                    // Writes depend only on the address-phase code; a WLAST
                    // mismatch downgrades the response but keeps writing.
                    if (err_q == RESP_OKAY) begin
                        mem_wen_d   = 1'b1;
                        mem_addr_d  = idx_q;
                        mem_wdata_d = bus.WDATA;
                        mem_wstrb_d = bus.WSTRB;
                    end
                    if (burst_q == BURST_INCR) begin
                        idx_d = idx_q + 1'b1;   // wraps modulo memory size
                    end else if (burst_q == BURST_FIXED) begin
                        idx_d = idx_q;
                    end
                    if (resp_q == RESP_OKAY && (bus.WLAST != last_beat)) begin
                        resp_d = RESP_SLVERR;
                    end
                    if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (bvalid_q && bus.BREADY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered copies of the next state so that
        // no input reaches an output combinationally.
        awready_d = (state_d == IDLE);
        wready_d  = (state_d == DATA);
        bvalid_d  = (state_d == RESP);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            id_q        <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            burst_q     <= '0;
            err_q       <= RESP_OKAY;
            resp_q      <= RESP_OKAY;
            beat_q      <= '0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            id_q        <= id_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            burst_q     <= burst_d;
            err_q       <= err_d;
            resp_q      <= resp_d;
            beat_q      <= beat_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BID     = id_q;
    assign bus.BRESP   = resp_q;

    assign MEM_WEN   = mem_wen_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign MEM_WSTRB = mem_wstrb_q;
endmodule

// File: tb/tb_axi4_wr_responder.sv
// ---------------------------------------------------------------------------
// tb_axi4_wr_responder
// Scoreboard bench: each transaction pushes its expected memory writes and
// B response; a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_axi4_wr_responder;
    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        mem_wen;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    wr_t  exp_wr[$];
    rsp_t exp_rsp[$];
    int   total = 0;
    int   bad = 0;
    int   wr_seen = 0;
    int   wr_expected = 0;

    axi4_wr_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

    axi4_wr_responder #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(6)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .bus(bus),
        .MEM_WEN(mem_wen),
        .MEM_ADDR(mem_addr),
        .MEM_WDATA(mem_wdata),
        .MEM_WSTRB(mem_wstrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares every memory write and every B handshake.
    always @(negedge clk) begin
        if (mem_wen === 1'b1) begin
            wr_t e;
            total++;
            wr_seen++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL mem_write unexpected: actual addr=%0d data=%h strb=%h required none",
                         mem_addr, mem_wdata, mem_wstrb);
            end else begin
                e = exp_wr.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data || mem_wstrb !== e.strb) begin
                    bad++;
                    $display("FAIL mem_write: actual addr=%0d data=%h strb=%h required addr=%0d data=%h strb=%h",
                             mem_addr, mem_wdata, mem_wstrb, e.addr, e.data, e.strb);
                end else begin
                    $display("write addr=%0d data=%h strb=%h ok", mem_addr, mem_wdata, mem_wstrb);
                end
            end
        end
        if (bus.BVALID === 1'b1 && bus.BREADY === 1'b1) begin
            rsp_t r;
            total++;
            if (exp_rsp.size() == 0) begin
                bad++;
                $display("FAIL bresp unexpected: actual id=%0d resp=%0d required none", bus.BID, bus.BRESP);
            end else begin
                r = exp_rsp.pop_front();
                if (bus.BID !== r.id || bus.BRESP !== r.resp) begin
                    bad++;
                    $display("FAIL bresp: actual id=%0d resp=%0d required id=%0d resp=%0d",
                             bus.BID, bus.BRESP, r.id, r.resp);
                end else begin
                    $display("resp id=%0d resp=%0d ok", bus.BID, bus.BRESP);
                end
            end
        end else if (bus.BVALID === 1'b1 && exp_rsp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL bvalid unexpected: actual id=%0d resp=%0d required no response", bus.BID, bus.BRESP);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=timeout required=handshake", name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, bus.AWREADY, 0);
        check({tag, "_wready"},  bus.WREADY, 0);
        check({tag, "_bvalid"},  bus.BVALID, 0);
        check({tag, "_bid"},     bus.BID, 0);
        check({tag, "_bresp"},   bus.BRESP, 0);
        check({tag, "_mem_wen"}, mem_wen, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_mem_wstrb"}, mem_wstrb, 0);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
        bus.AWSIZE = size; bus.AWBURST = burst; bus.AWVALID = 1'b1;
        while (bus.AWREADY !== 1'b1 && n < 200) begin step(); n++; end
        if (n >= 200) timeout("aw_handshake");
        step();
        bus.AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input bit last, input int gap);
        int n = 0;
        repeat (gap) step();
        bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
        while (bus.WREADY !== 1'b1 && n < 200) begin step(); n++; end
        if (n >= 200) timeout("w_handshake");
        step();
        bus.WVALID = 1'b0;
    endtask

    task automatic wait_resp(input logic [3:0] id, input logic [1:0] resp, input int bp);
        int n = 0;
        if (bp > 0) bus.BREADY = 1'b0;
        while (bus.BVALID !== 1'b1 && n < 200) begin step(); n++; end
        if (n >= 200) timeout("bvalid_wait");
        for (int i = 0; i < bp; i++) begin
            check("bp_bvalid", bus.BVALID, 1);
            check("bp_bid", bus.BID, id);
            check("bp_bresp", bus.BRESP, resp);
            check("bp_awready", bus.AWREADY, 0);
            check("bp_wready", bus.WREADY, 0);
            step();
        end
        bus.BREADY = 1'b1;
        step();
        check("post_b_bvalid", bus.BVALID, 0);
        check("post_b_awready", bus.AWREADY, 1);
    endtask

    // Issues one burst; the reference model derives expected writes and
    // response from the address, burst type and WLAST pattern.
    task automatic run_txn(input logic [3:0] id, input logic [11:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int early_last, input bit never_last, input int gap_max,
                           input int bp, input bit early_w, input bit fixed_data);
        logic [31:0] dat [256];
        logic [3:0]  stb [256];
        bit          lst [256];
        logic [1:0]  code;
        logic [1:0]  fin;
        int          idx;
        for (int i = 0; i <= len; i++) begin
            dat[i] = fixed_data ? 32'hDEADBEEF : $urandom;
            stb[i] = fixed_data ? 4'hF : 4'($urandom_range(1, 15));
            if (never_last)           lst[i] = 1'b0;
            else if (early_last >= 0) lst[i] = (i == early_last);
            else                      lst[i] = (i == len);
        end
        if (int'(addr) >= 256)                 code = 2'b11;
        else if (size != 3'd2 || burst >= 2)   code = 2'b10;
        else                                   code = 2'b00;
        fin = code;
        idx = (int'(addr) / 4) % 64;
        for (int i = 0; i <= len; i++) begin
            if (code == 2'b00) begin
                wr_t w;
                w.addr = 6'(idx); w.data = dat[i]; w.strb = stb[i];
                exp_wr.push_back(w);
                wr_expected++;
                if (burst == 2'b01) idx = (idx + 1) % 64;
                if (lst[i] != (i == len)) fin = 2'b10;
            end
        end
        begin
            rsp_t r;
            r.id = id; r.resp = fin;
            exp_rsp.push_back(r);
        end
        $display("txn id=%0d addr=%h len=%0d size=%0d burst=%0d expect resp=%0d", id, addr, len, size, burst, fin);

        if (early_w) begin
            // W presented before the address: must be stalled, not consumed.
            bus.WDATA = dat[0]; bus.WSTRB = stb[0]; bus.WLAST = lst[0]; bus.WVALID = 1'b1;
            repeat (3) begin step(); check("wready_idle", bus.WREADY, 0); end
        end
        send_aw(id, addr, 8'(len), size, burst);
        for (int i = 0; i <= len; i++) begin
            send_w(dat[i], stb[i], lst[i], (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
        end
        wait_resp(id, fin, bp);
    endtask

    initial begin
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();
        check("awready_after_reset", bus.AWREADY, 1);
        check("wready_after_reset", bus.WREADY, 0);

        // Single beat, with W offered early during IDLE.
        run_txn(4'h5, 12'h010, 0, 3'd2, 2'b01, -1, 0, 0, 0, 1, 1);
        // INCR wrap 62,63,0,1 and FIXED at index 8.
        run_txn(4'h1, 12'h0F8, 3, 3'd2, 2'b01, -1, 0, 0, 0, 0, 0);
        run_txn(4'h2, 12'h020, 3, 3'd2, 2'b00, -1, 0, 0, 0, 0, 0);
        // Error bursts.
        run_txn(4'h3, 12'h100, 2, 3'd2, 2'b01, -1, 0, 0, 0, 0, 0);
        run_txn(4'h4, 12'h040, 1, 3'd1, 2'b01, -1, 0, 0, 0, 0, 0);
        run_txn(4'h6, 12'h040, 3, 3'd2, 2'b10, -1, 0, 0, 0, 0, 0);
        // WLAST misuse.
        run_txn(4'h7, 12'h000, 2, 3'd2, 2'b01, 1, 0, 0, 0, 0, 0);
        run_txn(4'h8, 12'h030, 1, 3'd2, 2'b01, -1, 1, 0, 0, 0, 0);
        // Backpressure on B and gaps on W.
        run_txn(4'h9, 12'h080, 3, 3'd2, 2'b01, -1, 0, 3, 5, 0, 0);

        // Reset after 2 of 4 beats: the two writes stand, nothing else follows.
        begin
            wr_t w;
            $display("txn id=10 addr=040 len=3 reset after 2 beats");
            send_aw(4'hA, 12'h040, 8'd3, 3'd2, 2'b01);
            w.addr = 6'd16; w.data = 32'h11111111; w.strb = 4'hF; exp_wr.push_back(w); wr_expected++;
            w.addr = 6'd17; w.data = 32'h22222222; w.strb = 4'h3; exp_wr.push_back(w); wr_expected++;
            send_w(32'h11111111, 4'hF, 1'b0, 0);
            send_w(32'h22222222, 4'h3, 1'b0, 0);
            bus.WDATA = 32'h33333333; bus.WSTRB = 4'hF; bus.WLAST = 1'b0; bus.WVALID = 1'b1;
            rst = 1'b1;
            step();
            check_reset_outputs("midreset");
            bus.WVALID = 1'b0;
            step();
            rst = 1'b0;
            step();
            check("awready_after_midreset", bus.AWREADY, 1);
            check("mem_wen_after_midreset", mem_wen, 0);
        end
        run_txn(4'hB, 12'h044, 1, 3'd2, 2'b01, -1, 0, 0, 0, 0, 0);

        // Randomised bursts.
        for (int t = 0; t < 25; t++) begin
            logic [11:0] a;
            logic [2:0]  s;
            logic [1:0]  bt;
            int          r;
            int          el;
            bit          nl;
            int          ln;
            a  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 255));
            s  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
            r  = $urandom_range(0, 7);
            bt = (r < 5) ? 2'b01 : (r == 5) ? 2'b00 : (r == 6) ? 2'b10 : 2'b11;
            ln = $urandom_range(0, 7);
            el = -1;
            nl = 1'b0;
            r  = $urandom_range(0, 9);
            if (r == 0 && ln > 0) el = $urandom_range(0, ln - 1);
            else if (r == 1) nl = 1'b1;
            run_txn(4'($urandom), a, ln, s, bt, el, nl, 2, $urandom_range(0, 3), 0, 0);
        end

        repeat (3) step();
        check("write_count", wr_seen, wr_expected);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("rsp_queue_empty", exp_rsp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
